// File: rtl/click_decoder.sv
// Groups debounced key presses into single/double/.../MAX_CLICKS click events and queues them for a consumer.
// Define CLICK_EVT_FIFO_EN to get a 4-entry event FIFO instead of a single holding register.
module click_decoder #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int GAP_MS     = 300,
  parameter int MAX_CLICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_count,
  output logic       busy,
  output logic       overflow
);

  localparam logic [31:0] GAP_CNT = 32'((CLK_FREQ / 1000) * GAP_MS);
  localparam logic [2:0]  MAX_CNT = 3'(MAX_CLICKS);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  clicks_q, clicks_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  clicks_inc;
  logic [31:0] timer_inc;
  logic        max_hit, gap_hit;
  logic        emit;
  logic [2:0]  emit_count;
  logic        drop;
  logic        overflow_q;

  assign clicks_inc = clicks_q + 3'd1;
  assign timer_inc  = timer_q + 32'd1;
  // The press cycle itself counts as the first gap cycle, so the expiry test uses the advanced timer value.
  assign max_hit = (state_q == COLLECT) && key_flag && (clicks_inc == MAX_CNT);
  assign gap_hit = (state_q == COLLECT) && !key_flag && (timer_inc == GAP_CNT - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      clicks_q <= 3'd0;
      timer_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clicks_d = clicks_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (key_flag) begin
          state_d  = COLLECT;
          clicks_d = 3'd1;
          timer_d  = 32'd0;
        end
      end
      COLLECT: begin
        if (max_hit || gap_hit) begin
          state_d  = IDLE;
          clicks_d = 3'd0;
          timer_d  = 32'd0;
        end else if (key_flag) begin
          clicks_d = clicks_inc;
          timer_d  = 32'd0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == COLLECT);
    emit       = max_hit || gap_hit;
    emit_count = max_hit ? clicks_inc : clicks_q;
  end

`ifdef CLICK_EVT_FIFO_EN
  logic [2:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] fill_q;
  logic       push, pop;

  assign pop  = (fill_q != 3'd0) && evt_ready;
  // A slot freed by this cycle's transfer is available to this cycle's emit.
  assign push = emit && ((fill_q != 3'd4) || pop);
  assign drop = emit && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      fill_q   <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 3'd1;
        2'b01:   fill_q <= fill_q - 3'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= emit_count;
  end

  assign evt_valid = (fill_q != 3'd0);
  assign evt_count = evt_valid ? fifo_mem[rd_ptr_q] : 3'd0;
`else
  logic       hold_valid_q;
  logic [2:0] hold_count_q;
  logic       push;

  assign push = emit && (!hold_valid_q || evt_ready);
  assign drop = emit && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_count_q <= 3'd0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_count_q <= emit_count;
    end else if (hold_valid_q && evt_ready) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign evt_valid = hold_valid_q;
  assign evt_count = hold_count_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_click_decoder.sv
// Randomized scoreboard bench for click_decoder: a timestamp-based click model predicts events and storage occupancy.
module tb_click_decoder;

  localparam int CLK_FREQ = 10_000;
  localparam int GAP_MS   = 1;
  localparam int MAX_CLK  = 3;
  localparam int GAP_CNT  = (CLK_FREQ / 1000) * GAP_MS;
`ifdef CLICK_EVT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_flag = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [2:0] evt_count;
  logic       busy;
  logic       overflow;

  click_decoder #(.CLK_FREQ(CLK_FREQ), .GAP_MS(GAP_MS), .MAX_CLICKS(MAX_CLK)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_count(evt_count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int drained = 0;

  // Reference model: sequences tracked by press timestamps, storage as a bounded queue.
  int  cyc = 0;
  bit  in_seq = 0;
  int  seq_clicks = 0;
  int  last_press = 0;
  int  store[$];
  int  exp_q[$];
  bit  exp_ovf = 0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit key, bit ready);
    bit emit = 0;
    int ec = 0;
    if (key) begin
      if (!in_seq) begin
        in_seq = 1; seq_clicks = 1; last_press = cyc;
      end else begin
        seq_clicks++; last_press = cyc;
        if (seq_clicks == MAX_CLK) begin emit = 1; ec = seq_clicks; in_seq = 0; end
      end
    end else if (in_seq && (cyc - last_press == GAP_CNT - 1)) begin
      emit = 1; ec = seq_clicks; in_seq = 0;
    end
    if (store.size() > 0 && ready) void'(store.pop_front());
    if (emit) begin
      if (store.size() < CAP) begin
        store.push_back(ec);
        exp_q.push_back(ec);
      end else begin
        exp_ovf = 1;
      end
    end
    cyc++;
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the following posedge+1.
  task automatic cycle(bit key, bit ready);
    key_flag  = key;
    evt_ready = ready;
    model_step(key, ready);
    @(posedge clk); #1;
    check("busy", int'(busy), int'(in_seq));
    check("overflow", int'(overflow), int'(exp_ovf));
    check("evt_valid", int'(evt_valid), int'(store.size() > 0));
    if (store.size() > 0) check("evt_count", int'(evt_count), store[0]);
  endtask

  task automatic do_reset();
    key_flag = 0;
    rst = 1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_count", int'(evt_count), 0);
    check("rst_ovf", int'(overflow), 0);
    in_seq = 0; store.delete(); exp_q.delete(); exp_ovf = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic idle(int n, bit ready);
    for (int i = 0; i < n; i++) cycle(0, ready);
  endtask

  // Scoreboard monitor: every transfer must match the oldest predicted event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && evt_valid && evt_ready) begin
        drained++;
        if (exp_q.size() == 0) check("sb_unexpected_event", int'(evt_count), 0 - 1);
        else check("sb_count", int'(evt_count), exp_q.pop_front());
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    check("init_busy", int'(busy), 0);
    check("init_valid", int'(evt_valid), 0);
    check("init_count", int'(evt_count), 0);
    check("init_ovf", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 0;

    // Single click, double click, triple click with immediate emit and a back-to-back restart.
    cycle(1, 1); idle(14, 1);
    cycle(1, 1); idle(4, 1); cycle(1, 1); idle(14, 1);
    cycle(1, 1); idle(2, 1); cycle(1, 1); idle(2, 1); cycle(1, 1); cycle(0, 1); cycle(1, 1); idle(14, 1);
    // Emit followed one cycle later by a new press.
    cycle(1, 1); cycle(1, 1); cycle(1, 1); cycle(1, 1); idle(14, 1);

    // Consumer stalled: five single-click sequences overflow the storage.
    for (int s = 0; s < 5; s++) begin
      cycle(1, 0); idle(11, 0);
    end
    check("stall_overflow", int'(overflow), 1);
    check("stall_head", int'(evt_count), 1);
    drained = 0;
    idle(10, 1);
    check("stall_drained", drained, CAP);
    check("ovf_sticky", int'(overflow), 1);

    // Reset mid-sequence abandons it.
    do_reset();
    cycle(1, 1); idle(3, 1);
    do_reset();
    drained = 0;
    idle(15, 1);
    check("rst_no_event", drained, 0);

    // Randomized phase with bursts of backpressure and rare resets.
    for (int i = 0; i < 4000; i++) begin
      bit k, r;
      if ($urandom_range(0, 799) == 0) do_reset();
      k = ($urandom_range(0, 4) == 0);
      r = ((i / 60) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cycle(k, r);
    end

    idle(20, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
